// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_match_core.sv
// Shift history, fill tracking and Mealy pattern comparator for one serial stream.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_din,
  input  logic             i_din_vld,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic             i_overlap,
  output logic             o_match
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  w_window;

  // The incoming bit completes the window, so a match is seen in the same cycle.
  assign w_window = {r_hist, i_din};
  assign o_match  = rst & i_en & i_din_vld & (r_fill == FILL_MAX) & (w_window == i_pattern);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_en && i_din_vld) begin
      // Non-overlapping mode restarts collection so matched bits are not reused.
      if (o_match && !i_overlap) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_window[PAT_W-2:0];
        if (r_fill != FILL_MAX)
          r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial pattern detector: config, match counting and event handshake.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_vld,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             evt_vld,
  input  logic             evt_ready,
  output logic             done
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [PAT_W-1:0] r_pattern;
  logic             r_overlap;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic             w_match;
  logic             w_run;
  logic             w_cfg_wr;
  logic             w_start_ok;
  logic             w_cnt_upd;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_hit_target;
  logic             w_done_set;

  // A config write or an abort in the same cycle suppresses start.
  assign w_run        = (r_state == ST_RUN);
  assign w_cfg_wr     = (r_state == ST_IDLE) & cfg_we;
  assign w_start_ok   = (r_state == ST_IDLE) & start & ~cfg_we & ~abort;
  assign w_cnt_upd    = w_run & w_match & ~abort;
  assign w_cnt_inc    = sat_inc(r_cnt);
  assign w_hit_target = w_cnt_upd & (r_target != '0) & (w_cnt_inc == r_target);
  assign w_done_set   = (r_state == ST_REPORT) & evt_ready & ~abort;

  seq_match_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_start_ok),
    .i_en      (w_run),
    .i_din     (din),
    .i_din_vld (din_vld),
    .i_pattern (r_pattern),
    .i_overlap (r_overlap),
    .o_match   (w_match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    evt_vld = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok)
          w_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort)
          w_next = ST_IDLE;
        else if (w_hit_target)
          w_next = ST_REPORT;
      end
      ST_REPORT: begin
        busy    = 1'b1;
        evt_vld = 1'b1;
        if (abort || evt_ready)
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Config defaults after reset: all-ones pattern, non-overlapping, stop after one match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern <= '1;
      r_overlap <= 1'b0;
      r_target  <= CNT_W'(1);
    end else if (w_cfg_wr) begin
      r_pattern <= cfg_pattern;
      r_overlap <= cfg_overlap;
      r_target  <= cfg_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_start_ok)
        r_cnt <= '0;
      else if (w_cnt_upd)
        r_cnt <= w_cnt_inc;
    end
  end

  assign match     = w_match;
  assign match_cnt = r_cnt;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Randomized and directed bench for seq_det_ctrl against a bit-queue reference model.
module tb_seq_det_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             din = 1'b0;
  logic             din_vld = 1'b0;
  logic             evt_ready = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             evt_vld;
  logic             done;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .din         (din),
    .din_vld     (din_vld),
    .match       (match),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .evt_vld     (evt_vld),
    .evt_ready   (evt_ready),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 running, 2 reporting; bits kept since last restart.
  int               m_st;
  logic [PAT_W-1:0] m_pat;
  bit               m_ovl;
  int               m_tgt;
  int               m_cnt;
  bit               m_done;
  bit               m_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_match = 0;
  int n_done  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_cnt  = 0;
    m_done = 0;
    m_q.delete();
    m_pat  = '1;
    m_ovl  = 0;
    m_tgt  = 1;
  endtask

  function automatic bit model_match();
    logic [PAT_W-1:0] w;
    int base;
    if (m_st != 1 || !din_vld || !rst) return 0;
    if (m_q.size() < PAT_W - 1) return 0;
    base = m_q.size() - (PAT_W - 1);
    for (int i = 0; i < PAT_W - 1; i++)
      w[PAT_W-1-i] = m_q[base+i];
    w[0] = din;
    return w == m_pat;
  endfunction

  // Called at posedge+1 with inputs applied; checks mid-cycle, then advances model and clock.
  task automatic cycle();
    bit em;
    bit nd;
    #2;
    em = model_match();
    chk("match", match, em);
    chk("match_cnt", match_cnt, m_cnt);
    chk("busy", busy, m_st != 0);
    chk("evt_vld", evt_vld, m_st == 2);
    chk("done", done, m_done);
    if (match) n_match++;
    if (done) n_done++;
    if (rst) begin
      nd = (m_st == 2) && evt_ready && !abort;
      case (m_st)
        0: begin
          if (cfg_we) begin
            m_pat = cfg_pattern;
            m_ovl = cfg_overlap;
            m_tgt = cfg_target;
          end else if (start && !abort) begin
            m_st  = 1;
            m_cnt = 0;
            m_q.delete();
          end
        end
        1: begin
          if (abort) m_st = 0;
          else if (din_vld) begin
            m_q.push_back(din);
            if (em) begin
              if (m_cnt < MAXC) m_cnt++;
              if (!m_ovl) m_q.delete();
              if (m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
            end
            while (m_q.size() > PAT_W) void'(m_q.pop_front());
          end
        end
        default: begin
          if (abort || evt_ready) m_st = 0;
        end
      endcase
      m_done = nd;
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    abort   = 1'b0;
    cfg_we  = 1'b0;
    din_vld = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b0;
    model_reset();
    repeat (ncyc) cycle();
    rst = 1'b1;
  endtask

  task automatic cfg(input logic [PAT_W-1:0] p, input bit o, input int t);
    cfg_pattern = p;
    cfg_overlap = o;
    cfg_target  = CNT_W'(t);
    cfg_we      = 1'b1;
    cycle();
  endtask

  task automatic go();
    start = 1'b1;
    cycle();
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      din     = bits[n-1-i];
      din_vld = 1'b1;
      cycle();
    end
  endtask

  task automatic stop_run();
    abort = 1'b1;
    cycle();
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_busy", busy, 0);

    // cfg_we with start: config taken, run not started
    cfg_pattern = 4'b1101; cfg_overlap = 1'b0; cfg_target = 8'd2;
    cfg_we = 1'b1; start = 1'b1;
    cycle();
    chk("cfg_start_busy", busy, 0);

    // Non-overlapping, target 2
    go();
    n_match = 0;
    feed(16'b11011101, 8);
    chk("nonovl_matches", n_match, 2);
    chk("nonovl_evt", evt_vld, 1);
    chk("nonovl_cnt", match_cnt, 2);
    n_done = 0;
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
    cycle();
    chk("nonovl_done", n_done, 1);

    // Overlapping vs non-overlapping on 1101101
    cfg(4'b1101, 1'b1, 2);
    go();
    n_match = 0;
    feed(16'b1101101, 7);
    chk("ovl_matches", n_match, 2);
    chk("ovl_evt", evt_vld, 1);
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
    cfg(4'b1101, 1'b0, 0);
    go();
    n_match = 0;
    feed(16'b1101101, 7);
    chk("nonovl_single", n_match, 1);
    stop_run();

    // Event held while evt_ready low
    cfg(4'b1101, 1'b1, 1);
    go();
    feed(16'b1101, 4);
    n_done = 0;
    repeat (5) begin
      din = 1'b1; din_vld = 1'b1;
      cycle();
    end
    chk("hold_evt", evt_vld, 1);
    chk("hold_cnt", match_cnt, 1);
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
    repeat (3) cycle();
    chk("hold_done_once", n_done, 1);

    // din_vld gaps inside the pattern
    cfg(4'b1101, 1'b0, 0);
    go();
    n_match = 0;
    for (int i = 0; i < 4; i++) begin
      din = (i == 2) ? 1'b0 : 1'b1; din_vld = 1'b1;
      cycle();
      repeat (2) begin
        din = 1'($urandom); din_vld = 1'b0;
        cycle();
      end
    end
    chk("gap_matches", n_match, 1);
    stop_run();

    // Abort just before the target match, then reset mid-run
    cfg(4'b1101, 1'b0, 2);
    go();
    n_done = 0;
    feed(16'b1101, 4);
    feed(16'b110, 3);
    stop_run();
    din = 1'b1; din_vld = 1'b1;
    cycle();
    chk("abort_evt", evt_vld, 0);
    chk("abort_cnt_hold", match_cnt, 1);
    go();
    feed(16'b11, 2);
    do_reset(2);
    chk("midrst_cnt", match_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("abort_no_done", n_done, 0);

    // Config write during RUN is ignored
    cfg(4'b1101, 1'b0, 0);
    go();
    cfg_pattern = 4'b0000; cfg_we = 1'b1;
    cycle();
    n_match = 0;
    feed(16'b0000, 4);
    chk("runcfg_old_none", n_match, 0);
    feed(16'b1101, 4);
    chk("runcfg_old_hit", n_match, 1);
    stop_run();
    cfg(4'b0000, 1'b0, 0);
    go();
    n_match = 0;
    feed(16'b0000, 4);
    chk("newcfg_hit", n_match, 1);
    stop_run();

    // Counter saturation in free-run overlap mode
    cfg(4'b1111, 1'b1, 0);
    go();
    repeat (265) begin
      din = 1'b1; din_vld = 1'b1;
      cycle();
    end
    chk("sat_cnt", match_cnt, MAXC);
    stop_run();

    // Randomized traffic
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else begin
        cfg_we      = ($urandom_range(0, 19) == 0);
        cfg_pattern = PAT_W'($urandom);
        cfg_overlap = 1'($urandom);
        cfg_target  = CNT_W'($urandom_range(0, 3));
        start       = ($urandom_range(0, 7) == 0);
        abort       = ($urandom_range(0, 39) == 0);
        din         = 1'($urandom);
        din_vld     = ($urandom_range(0, 3) != 0);
        evt_ready   = ($urandom_range(0, 2) == 0);
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
